fifo_share_ctrl: RTL

- Controller that shares one fifo_2 instance (8-bit, 16-deep) between two write requesters and one read requester.
- Performs round-robin write arbitration and tracks occupancy so the FIFO never sees a write when full or a read when empty.
- Provides a flush sequence that drains the FIFO.
- Sits between producer/consumer logic and fifo_2, driving its en_write/en_read/data_in directly.

---
 rtl/fifo_share_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_share_ctrl.sv
// Shares one fifo_2 between two round-robin write requesters and one reader,
// tracking occupancy so the FIFO is never over/underrun, with a flush/drain sequence.
module fifo_share_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    input  logic              rd_req,
    output logic              rd_gnt,
    input  logic              flush,
    output logic              flush_done,
    output logic              fifo_en_write,
    output logic [DATA_W-1:0] fifo_data_in,
    output logic              fifo_en_read,
    input  logic              fifo_overflow,
    input  logic              fifo_underflow,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              err
);

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t state;
    logic   rr;
    logic   in_run;
    logic   rd_run;
    logic   rd_drain;
    logic   rd_any;
    logic   wr_ok;
    logic   wr_any;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO may still accept a write when a read retires an entry the same cycle.
    always_comb begin
        in_run   = (state == RUN);
        rd_run   = in_run && rd_req && !empty;
        rd_drain = (state == FLUSH) && !empty;
        rd_any   = rd_run || rd_drain;
        wr_ok    = in_run && !flush && (!full || rd_run);
        gnt0     = wr_ok && req0 && (!req1 || !rr);
        gnt1     = wr_ok && req1 && (!req0 || rr);
        wr_any   = gnt0 || gnt1;
        rd_gnt   = rd_run;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= RUN;
            rr            <= 1'b0;
            count         <= '0;
            fifo_en_write <= 1'b0;
            fifo_data_in  <= '0;
            fifo_en_read  <= 1'b0;
            flush_done    <= 1'b0;
            err           <= 1'b0;
        end else begin
            fifo_en_write <= wr_any;
            fifo_en_read  <= rd_any;
            if (gnt0) begin
                fifo_data_in <= data0;
                rr           <= 1'b1;
            end else if (gnt1) begin
                fifo_data_in <= data1;
                rr           <= 1'b0;
            end
            if (wr_any && !rd_any) begin
                count <= count + CNT_W'(1);
            end else if (!wr_any && rd_any) begin
                count <= count - CNT_W'(1);
            end
            err        <= err | fifo_overflow | fifo_underflow;
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush) state <= FLUSH;
                end
                FLUSH: begin
                    // Wait for the last issued read to reach the FIFO before finishing.
                    if (empty && !fifo_en_read) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
